// File: rtl/ov9655cpt_pkg.sv
// Shared types and command codes for the OV9655 capture sequencer.
package ov9655cpt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARM      = 2'd1,
    ST_CAPTURE  = 2'd2,
    ST_STOPPING = 2'd3
  } cpt_state_e;

  localparam logic [1:0] CTRL_STOP  = 2'd0;
  localparam logic [1:0] CTRL_START = 2'd1;
  localparam logic [1:0] CTRL_ABORT = 2'd2;

endpackage

// File: rtl/ov9655cpt_line_chk.sv
// Per-line byte counter; flags a sticky error when a line's byte count differs from line_size.
module ov9655cpt_line_chk #(
  parameter int CNT_W = 32
) (
  input  logic             clk_int,
  input  logic             reset_int,
  input  logic             clr,
  input  logic             en,
  input  logic             pix_valid,
  input  logic             line_end,
  input  logic [CNT_W-1:0] line_size,
  output logic             err
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_total;

  // A byte accepted on the line_end cycle still belongs to the line being closed.
  assign cnt_total = cnt_q + CNT_W'(pix_valid);

  always_ff @(posedge clk_int) begin
    if (reset_int) begin
      cnt_q <= '0;
      err   <= 1'b0;
    end else begin
      if (clr) err <= 1'b0;
      if (!en) begin
        cnt_q <= '0;
      end else if (line_end) begin
        cnt_q <= '0;
        if (cnt_total != line_size) err <= 1'b1;
      end else if (pix_valid) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ov9655_capture_seq.sv
// OV9655 frame capture sequencer: arms on START, captures whole frames, counts them.
// Optional line-length checking is built when OV9655CPT_LINE_CHECK_EN is defined.
//
// state    | meaning
// IDLE     | stopped, capture gated off
// ARM      | waiting for frame_start so a frame is never captured partially
// CAPTURE  | capture enabled, counting the frame on frame_end
// STOPPING | STOP seen mid-frame; finish and count this frame, then IDLE
module ov9655_capture_seq
  import ov9655cpt_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_int,
  input  logic             reset_int,
  input  logic [1:0]       ctrl_i,
  input  logic             ctrl_strb_i,
  input  logic [CNT_W-1:0] frames_set_i,
  input  logic [CNT_W-1:0] line_size_i,
  input  logic             frame_start_i,
  input  logic             frame_end_i,
  input  logic             pix_valid_i,
  input  logic             line_end_i,
  output logic             cap_en_o,
  output logic             act_o,
  output logic [CNT_W-1:0] frames_cur_o,
  output logic             done_o,
  output logic             err_o
);

  cpt_state_e       state_q, state_d;
  logic             cnt_evt, done_evt;
  logic             start_cmd, stop_cmd, abort_cmd, clr_run;
  logic [CNT_W-1:0] frames_inc;
  logic             target_hit;

  assign start_cmd  = ctrl_strb_i && (ctrl_i == CTRL_START);
  assign stop_cmd   = ctrl_strb_i && (ctrl_i == CTRL_STOP);
  assign abort_cmd  = ctrl_strb_i && (ctrl_i == CTRL_ABORT);
  assign clr_run    = (state_q == ST_IDLE) && start_cmd;
  assign frames_inc = frames_cur_o + CNT_W'(1);
  assign target_hit = (frames_set_i != '0) && (frames_inc == frames_set_i);

  always_ff @(posedge clk_int) begin
    if (reset_int) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_evt  = 1'b0;
    done_evt = 1'b0;
    case (state_q)
      ST_IDLE: if (start_cmd) state_d = ST_ARM;
      ST_ARM: begin
        if (stop_cmd)           state_d = ST_IDLE;
        else if (frame_start_i) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // A coincident frame_start is deliberately left unconsumed: we re-arm and wait.
        if (frame_end_i) begin
          cnt_evt = 1'b1;
          if (target_hit) begin
            state_d  = ST_IDLE;
            done_evt = 1'b1;
          end else if (stop_cmd) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ARM;
          end
        end else if (stop_cmd) begin
          state_d = ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        if (frame_end_i) begin
          cnt_evt = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_cmd) begin
      state_d  = ST_IDLE;
      cnt_evt  = 1'b0;
      done_evt = 1'b0;
    end
  end

  always_comb begin
    cap_en_o = (state_q == ST_CAPTURE) || (state_q == ST_STOPPING);
    act_o    = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk_int) begin
    if (reset_int) begin
      frames_cur_o <= '0;
      done_o       <= 1'b0;
    end else begin
      done_o <= done_evt;
      if (clr_run)      frames_cur_o <= '0;
      else if (cnt_evt) frames_cur_o <= frames_inc;
    end
  end

`ifdef OV9655CPT_LINE_CHECK_EN
  ov9655cpt_line_chk #(
    .CNT_W (CNT_W)
  ) u_line_chk (
    .clk_int   (clk_int),
    .reset_int (reset_int),
    .clr       (clr_run),
    .en        (cap_en_o),
    .pix_valid (pix_valid_i),
    .line_end  (line_end_i),
    .line_size (line_size_i),
    .err       (err_o)
  );
`else
  logic unused_line_inputs;
  assign unused_line_inputs = ^{line_size_i, pix_valid_i, line_end_i};
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ov9655_capture_seq.sv
// Directed self-checking bench for ov9655_capture_seq (line check exercised when OV9655CPT_LINE_CHECK_EN is defined).
module tb_ov9655_capture_seq;

  localparam int CNT_W = 32;

  logic             clk_int = 1'b0;
  logic             reset_int = 1'b1;
  logic [1:0]       ctrl_i = 2'd0;
  logic             ctrl_strb_i = 1'b0;
  logic [CNT_W-1:0] frames_set_i = '0;
  logic [CNT_W-1:0] line_size_i = '0;
  logic             frame_start_i = 1'b0;
  logic             frame_end_i = 1'b0;
  logic             pix_valid_i = 1'b0;
  logic             line_end_i = 1'b0;
  logic             cap_en_o, act_o, done_o, err_o;
  logic [CNT_W-1:0] frames_cur_o;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  ov9655_capture_seq #(.CNT_W(CNT_W)) dut (
    .clk_int       (clk_int),
    .reset_int     (reset_int),
    .ctrl_i        (ctrl_i),
    .ctrl_strb_i   (ctrl_strb_i),
    .frames_set_i  (frames_set_i),
    .line_size_i   (line_size_i),
    .frame_start_i (frame_start_i),
    .frame_end_i   (frame_end_i),
    .pix_valid_i   (pix_valid_i),
    .line_end_i    (line_end_i),
    .cap_en_o      (cap_en_o),
    .act_o         (act_o),
    .frames_cur_o  (frames_cur_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk_int = ~clk_int;

  always @(negedge clk_int) if (done_o === 1'b1) done_cnt++;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_int);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [1:0] code);
    ctrl_i = code; ctrl_strb_i = 1'b1;
    step();
    ctrl_strb_i = 1'b0;
  endtask

  task automatic fs();
    frame_start_i = 1'b1; step(); frame_start_i = 1'b0;
  endtask

  task automatic fe();
    frame_end_i = 1'b1; step(); frame_end_i = 1'b0;
  endtask

  initial begin
    // reset state
    step(2);
    chk("rst_cap_en", cap_en_o, 0);
    chk("rst_act", act_o, 0);
    chk("rst_frames", frames_cur_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    reset_int = 1'b0;
    step();

    // ignored commands while idle
    cmd(2'd0);
    chk("stop_idle_act", act_o, 0);
    cmd(2'd3);
    chk("code3_idle_act", act_o, 0);

    // counted run of 3, fourth frame not captured
    frames_set_i = 3;
    cmd(2'd1);
    chk("arm_act", act_o, 1);
    chk("arm_cap_en", cap_en_o, 0);
    for (int f = 1; f <= 3; f++) begin
      fs();
      chk("cap_en_in_frame", cap_en_o, 1);
      step(3);
      fe();
      chk("frames_after_fe", frames_cur_o, CNT_W'(f));
      chk("cap_en_after_fe", cap_en_o, 0);
    end
    chk("run3_done", done_o, 1);
    chk("run3_act", act_o, 0);
    step();
    chk("run3_done_one_cycle", done_o, 0);
    fs();
    chk("f4_cap_en", cap_en_o, 0);
    chk("f4_act", act_o, 0);
    fe();
    chk("f4_frames", frames_cur_o, 3);
    chk("run3_done_cnt", done_cnt, 1);

    // START mid-frame: in-progress frame is skipped
    frames_set_i = 2;
    fs();
    step(2);
    cmd(2'd1);
    chk("mid_start_frames_clr", frames_cur_o, 0);
    chk("mid_start_cap_en", cap_en_o, 0);
    step(2);
    fe();
    chk("mid_start_partial_not_counted", frames_cur_o, 0);
    chk("mid_start_cap_en_hold", cap_en_o, 0);
    fs();
    chk("mid_start_cap_en_next", cap_en_o, 1);
    fe();
    chk("mid_start_frames1", frames_cur_o, 1);
    fs(); fe();
    chk("mid_start_frames2", frames_cur_o, 2);
    chk("mid_start_done", done_o, 1);

    // continuous, 5 frames, STOP mid-frame 6
    frames_set_i = 0;
    step();
    cmd(2'd1);
    for (int f = 1; f <= 5; f++) begin
      fs(); step(2); fe();
    end
    chk("cont_frames5", frames_cur_o, 5);
    chk("cont_act", act_o, 1);
    fs();
    step(2);
    cmd(2'd0);
    chk("stopping_cap_en", cap_en_o, 1);
    chk("stopping_act", act_o, 1);
    step(3);
    chk("stopping_cap_en_hold", cap_en_o, 1);
    fe();
    chk("stop_frames6", frames_cur_o, 6);
    chk("stop_act", act_o, 0);
    chk("stop_cap_en", cap_en_o, 0);
    chk("stop_done_cnt", done_cnt, 2);

    // coincident end+start re-arms without consuming the start; START ignored while active
    cmd(2'd1);
    fs();
    cmd(2'd1);
    chk("start_ignored_capture", cap_en_o, 1);
    frame_end_i = 1'b1; frame_start_i = 1'b1;
    step();
    frame_end_i = 1'b0; frame_start_i = 1'b0;
    chk("coinc_frames", frames_cur_o, 1);
    chk("coinc_cap_en", cap_en_o, 0);
    chk("coinc_act", act_o, 1);
    step();
    chk("coinc_still_armed", cap_en_o, 0);
    fs();
    chk("coinc_next_start", cap_en_o, 1);
    cmd(2'd2);
    chk("abort_act", act_o, 0);
    chk("abort_frames", frames_cur_o, 1);

    // ABORT mid-frame 2 of 4
    frames_set_i = 4;
    cmd(2'd1);
    fs(); step(2); fe();
    fs(); step(2);
    cmd(2'd2);
    chk("abort2_act", act_o, 0);
    chk("abort2_cap_en", cap_en_o, 0);
    chk("abort2_frames", frames_cur_o, 1);
    fe();
    chk("abort2_late_fe", frames_cur_o, 1);

    // frames_set sampled at the comparison, not at START
    frames_set_i = 5;
    cmd(2'd1);
    fs();
    frames_set_i = 1;
    fe();
    chk("live_set_done", done_o, 1);
    chk("live_set_act", act_o, 0);
    chk("live_set_frames", frames_cur_o, 1);

    // reset during CAPTURE
    frames_set_i = 0;
    cmd(2'd1);
    fs(); step(2);
    reset_int = 1'b1;
    step();
    reset_int = 1'b0;
    chk("rst_mid_cap_en", cap_en_o, 0);
    chk("rst_mid_act", act_o, 0);
    chk("rst_mid_frames", frames_cur_o, 0);
    chk("rst_mid_done", done_o, 0);
    fe();
    chk("rst_mid_fe_frames", frames_cur_o, 0);
    chk("rst_mid_fe_act", act_o, 0);

`ifdef OV9655CPT_LINE_CHECK_EN
    line_size_i = 640;
    cmd(2'd1);
    fs();
    for (int i = 0; i < 640; i++) begin
      pix_valid_i = 1'b1; line_end_i = (i == 639);
      step();
    end
    pix_valid_i = 1'b0; line_end_i = 1'b0;
    chk("line640_err", err_o, 0);
    for (int i = 0; i < 640; i++) begin
      pix_valid_i = 1'b1; step();
    end
    pix_valid_i = 1'b0; line_end_i = 1'b1; step(); line_end_i = 1'b0;
    chk("line640_late_end_err", err_o, 0);
    for (int i = 0; i < 639; i++) begin
      pix_valid_i = 1'b1; line_end_i = (i == 638);
      step();
    end
    pix_valid_i = 1'b0; line_end_i = 1'b0;
    chk("line639_err", err_o, 1);
    fe();
    cmd(2'd2);
    chk("err_sticky_idle", err_o, 1);
    cmd(2'd1);
    chk("err_clr_start", err_o, 0);
    cmd(2'd2);
`else
    chk("err_tied_low", err_o, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ov9655_capture_seq.md
OV9655_CAPTURE_SEQ -- requirements
Module: ov9655_capture_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the frame counter and the line byte counter.
REQ-002 SHALL have port clk_int  in  1: sole clock; all logic rises on clk_int.
REQ-003 SHALL have port reset_int  in  1: synchronous, active-high reset.
REQ-004 SHALL have port ctrl_i  in  2: command code: 0 STOP, 1 START, 2 ABORT, 3 reserved.
REQ-005 SHALL have port ctrl_strb_i  in  1: one-cycle pulse qualifying ctrl_i.
REQ-006 SHALL have port frames_set_i  in  CNT_W: frames to capture per START; 0 means continuous.
REQ-007 SHALL have port line_size_i  in  CNT_W: expected bytes per line.
REQ-008 SHALL have port frame_start_i  in  1: pulse, sensor VSYNC start, already in clk_int domain.
REQ-009 SHALL have port frame_end_i  in  1: pulse, last pixel of frame accepted by datapath.
REQ-010 SHALL have port pix_valid_i  in  1: one byte accepted by datapath this cycle.
REQ-011 SHALL have port line_end_i  in  1: pulse, HREF falling, coincident with or after the last pix_valid_i of the line.
REQ-012 SHALL have port cap_en_o  out  1: gates pixel write into the capture datapath.
REQ-013 SHALL have port act_o  out  1: sequencer not IDLE.
REQ-014 SHALL have port frames_cur_o  out  CNT_W: completed frames since last START.
REQ-015 SHALL have port done_o  out  1: one-cycle pulse when a counted run finishes.
REQ-016 SHALL have port err_o  out  1: sticky line-length error flag.

Function
REQ-017 SHALL implement states IDLE, ARM, CAPTURE, STOPPING.
REQ-018 IDLE + START strobe SHALL go to ARM and clear frames_cur_o and err_o in the same edge.
REQ-019 ARM SHALL hold cap_en_o=0 and go to CAPTURE on frame_start_i, so that a frame already in progress is never captured partially.
REQ-020 CAPTURE SHALL drive cap_en_o=1 combinationally from state, with zero cycles of latency after entry.
REQ-021 On frame_end_i in CAPTURE, the block SHALL increment frames_cur_o by 1 (wrap modulo 2^CNT_W).
REQ-022 If frames_set_i≠0 and the incremented count equals frames_set_i, the block SHALL go to IDLE and pulse done_o for one cycle; otherwise it SHALL go to ARM.
REQ-023 frame_end_i and frame_start_i in the same CAPTURE cycle SHALL be handled as end-then-re-arm; the start is not consumed.
REQ-024 STOP strobe in ARM SHALL go to IDLE; STOP in CAPTURE SHALL go to STOPPING, which finishes the frame, counts it on frame_end_i, then goes to IDLE with no done_o.
REQ-025 ABORT strobe in any state SHALL go to IDLE next cycle with cap_en_o=0; the partial frame SHALL NOT be counted.
REQ-026 START while not IDLE, STOP while IDLE, and code 3 SHALL be ignored.
REQ-027 frames_set_i SHALL be sampled at each comparison, not latched at START.
REQ-028 act_o SHALL be 1 in every state except IDLE.

Reset
REQ-029 While reset_int=1 at a clk_int edge, the block SHALL set state=IDLE, cap_en_o=0, act_o=0, frames_cur_o=0, done_o=0, err_o=0, and clear the line counter.
REQ-030 Reset asserted mid-frame SHALL take effect at the next edge; no frame SHALL be counted.

Configuration
REQ-031 Macro OV9655CPT_LINE_CHECK_EN defined: in CAPTURE, the line counter SHALL count pix_valid_i; on line_end_i it SHALL compare the count (including a same-cycle byte) with line_size_i, set err_o on mismatch, and reset the counter.
REQ-032 Macro OV9655CPT_LINE_CHECK_EN undefined: the block SHALL contain no line counter and SHALL tie err_o to 0.

Structure
REQ-033 Package ov9655cpt_pkg SHALL hold the state enum and the ctrl code constants (CTRL_STOP, CTRL_START, CTRL_ABORT).
REQ-034 The line check SHALL be sub-module ov9655cpt_line_chk, instantiated only under the macro.

Verification
REQ-035 frames_set=3, START, 4 frame_start/end pairs -> frames_cur_o=3, done_o pulses once, 4th frame has cap_en_o=0, act_o=0.
REQ-036 START asserted mid-frame -> cap_en_o stays 0 until the next frame_start_i, and that first frame_end_i does not count.
REQ-037 frames_set=0, 5 frames, then STOP mid-frame 6 -> cap_en_o held to frame_end, frames_cur_o=6, no done_o.
REQ-038 ABORT mid-frame 2 of frames_set=4 -> IDLE next cycle, frames_cur_o=1, cap_en_o=0.
REQ-039 With macro defined and line_size=640: lines of 640 bytes give err_o=0; one line of 639 bytes gives err_o=1, held until next START.
REQ-040 reset_int pulse during CAPTURE -> all outputs 0 at next edge; a following frame_end_i gives no count.
